// File: rtl/rf_forest_ctrl_pkg.sv
// Shared sizing, state encoding and constants for the random-forest sequencing controller.
// Pure declarations: no latency or backpressure of its own.
package rf_pkg;
    localparam int NUM_FEATURES = 8;
    localparam int NUM_TREES    = 16;
    localparam int NUM_CLASSES  = 4;
    localparam int CLASS_W      = 2;
    localparam int TREE_ID_W    = 4;
    localparam int FEAT_IDX_W   = 3;
    // Sized so that a single class can collect every tree's vote
    localparam int VOTE_W       = $clog2(NUM_TREES + 1);

    localparam logic [7:0] ASCII_ZERO = 8'h30;

    typedef enum logic [2:0] {
        COLLECT,
        START,
        WAIT,
        ARGMAX,
        SEND
    } state_e;
endpackage

// File: rtl/rf_forest_ctrl_if.sv
// UART byte streams, tree-engine handshake and status bundle of the forest controller.
// master drives receive bytes, engine replies and tx_ready; slave is the controller.
interface rf_forest_ctrl_if import rf_pkg::*; ();
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic [FEAT_IDX_W-1:0] feat_idx;
    logic [7:0]            feat_data;
    logic                  eng_start;
    logic [TREE_ID_W-1:0]  eng_tree_id;
    logic                  eng_done;
    logic [CLASS_W-1:0]    eng_class;
    logic                  tx_valid;
    logic [7:0]            tx_data;
    logic                  tx_ready;
    logic [7:0]            result;
    logic                  busy;
    logic                  bad_class;

    modport master (
        output rx_valid, rx_data, feat_idx, eng_done, eng_class, tx_ready,
        input  feat_data, eng_start, eng_tree_id, tx_valid, tx_data, result, busy, bad_class
    );

    modport slave (
        input  rx_valid, rx_data, feat_idx, eng_done, eng_class, tx_ready,
        output feat_data, eng_start, eng_tree_id, tx_valid, tx_data, result, busy, bad_class
    );
endinterface

// File: rtl/rf_vote_tally.sv
// Per-class vote counters plus a one-class-per-cycle argmax; scan_done/winner appear
// N_CLASSES cycles after scan_start. No backpressure: the caller sequences clear/inc/scan.
module rf_vote_tally import rf_pkg::*; #(
    parameter int N_CLASSES = NUM_CLASSES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               inc,
    input  logic [CLASS_W-1:0] inc_class,
    input  logic               scan_start,
    output logic               scan_done,
    output logic [CLASS_W-1:0] winner
);
    localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(N_CLASSES - 1);

    logic [VOTE_W-1:0]  votes_q [N_CLASSES];
    logic               scanning_q;
    logic [CLASS_W-1:0] idx_q;
    logic [CLASS_W-1:0] best_q;
    logic [VOTE_W-1:0]  best_cnt_q;
    logic               take;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int c = 0; c < N_CLASSES; c++) votes_q[c] <= '0;
        end else if (inc) begin
            votes_q[inc_class] <= votes_q[inc_class] + VOTE_W'(1);
        end
    end

    // Strictly-greater replacement keeps the lowest index on ties
    assign take      = votes_q[idx_q] > best_cnt_q;
    assign winner    = take ? idx_q : best_q;
    assign scan_done = scanning_q && (idx_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            scanning_q <= 1'b0;
            idx_q      <= '0;
            best_q     <= '0;
            best_cnt_q <= '0;
        end else if (scan_start) begin
            scanning_q <= 1'b1;
            idx_q      <= '0;
            best_q     <= '0;
            best_cnt_q <= '0;
        end else if (scanning_q) begin
            if (take) begin
                best_q     <= idx_q;
                best_cnt_q <= votes_q[idx_q];
            end
            idx_q <= idx_q + CLASS_W'(1);
            if (scan_done) scanning_q <= 1'b0;
        end
    end
endmodule

// File: rtl/rf_forest_ctrl.sv
// Collects a feature vector, runs every tree on the shared engine, votes and sends one ASCII byte.
// First eng_start 1 cycle after the last byte; tx_valid is held until tx_ready, rx is dropped while busy.
module rf_forest_ctrl import rf_pkg::*; #(
    parameter int N_CLASSES = NUM_CLASSES
) (
    input  logic              clk,
    input  logic              rst,
    rf_forest_ctrl_if.slave   bus
);
    localparam logic [FEAT_IDX_W-1:0] LAST_BYTE = FEAT_IDX_W'(NUM_FEATURES - 1);
    localparam logic [TREE_ID_W-1:0]  LAST_TREE = TREE_ID_W'(NUM_TREES - 1);
    localparam logic [CLASS_W:0]      CLASS_LIM = (CLASS_W + 1)'(N_CLASSES);

    state_e                state_q, state_d;
    logic [FEAT_IDX_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [TREE_ID_W-1:0]  tree_q, tree_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic [7:0]            result_q, result_d;
    logic                  bad_q, bad_d;
    logic [7:0]            feat_q [NUM_FEATURES];

    logic                  feat_we, vote_clr, vote_inc, scan_start, scan_done;
    logic [CLASS_W-1:0]    winner;
    logic                  class_ok;

    assign class_ok = {1'b0, bus.eng_class} < CLASS_LIM;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        tree_d     = tree_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        result_d   = result_q;
        bad_d      = bad_q;
        feat_we    = 1'b0;
        vote_clr   = 1'b0;
        vote_inc   = 1'b0;
        scan_start = 1'b0;
        case (state_q)
            COLLECT: if (bus.rx_valid) begin
                feat_we    = 1'b1;
                byte_cnt_d = byte_cnt_q + FEAT_IDX_W'(1);
                if (byte_cnt_q == LAST_BYTE) begin
                    byte_cnt_d = '0;
                    vote_clr   = 1'b1;
                    tree_d     = '0;
                    state_d    = START;
                end
            end
            START: state_d = WAIT;
            WAIT: if (bus.eng_done) begin
                if (class_ok) vote_inc = 1'b1;
                else          bad_d    = 1'b1;
                if (tree_q == LAST_TREE) begin
                    scan_start = 1'b1;
                    state_d    = ARGMAX;
                end else begin
                    tree_d  = tree_q + TREE_ID_W'(1);
                    state_d = START;
                end
            end
            ARGMAX: if (scan_done) begin
                result_d   = {{(8 - CLASS_W){1'b0}}, winner};
                tx_data_d  = ASCII_ZERO + {{(8 - CLASS_W){1'b0}}, winner};
                tx_valid_d = 1'b1;
                state_d    = SEND;
            end
            SEND: if (bus.tx_ready) begin
                tx_valid_d = 1'b0;
                state_d    = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= COLLECT;
            byte_cnt_q <= '0;
            tree_q     <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            result_q   <= '0;
            bad_q      <= 1'b0;
            for (int f = 0; f < NUM_FEATURES; f++) feat_q[f] <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            tree_q     <= tree_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            result_q   <= result_d;
            bad_q      <= bad_d;
            if (feat_we) feat_q[byte_cnt_q] <= bus.rx_data;
        end
    end

    rf_vote_tally #(.N_CLASSES(N_CLASSES)) u_tally (
        .clk       (clk),
        .rst       (rst),
        .clear     (vote_clr),
        .inc       (vote_inc),
        .inc_class (bus.eng_class),
        .scan_start(scan_start),
        .scan_done (scan_done),
        .winner    (winner)
    );

    assign bus.feat_data   = feat_q[bus.feat_idx];
    assign bus.eng_start   = (state_q == START);
    assign bus.eng_tree_id = tree_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.result      = result_q;
    assign bus.busy        = (state_q != COLLECT);
    assign bus.bad_class   = bad_q;
endmodule

// File: tb/tb_rf_forest_ctrl.sv
// Scoreboard bench: two controllers (4 and 3 classes), behavioural tree engines, tx monitors.
module tb_rf_forest_ctrl;
    import rf_pkg::*;

    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    rf_forest_ctrl_if ifa ();
    rf_forest_ctrl_if ifb ();

    rf_forest_ctrl u_dut (.clk(clk), .rst(rst), .bus(ifa));
    rf_forest_ctrl #(.N_CLASSES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(ifb));

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [1:0] cls_a [16];
    logic [1:0] cls_b [16];
    logic [7:0] feat_a [8];
    logic [7:0] feat_b [8];
    int ecnt_a = 0, ecnt_b = 0;
    int lat_a = 2, lat_b = 1;
    int id_a, id_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Engine models: check tree order, read back a feature, answer after lat cycles
    initial forever begin
        @(negedge clk);
        if (ifa.eng_start) begin
            id_a = int'(ifa.eng_tree_id);
            chk("tree_id_a", 32'(ifa.eng_tree_id), 32'(ecnt_a));
            ecnt_a++;
            @(posedge clk); #1 ifa.feat_idx = 3'(id_a % 8);
            @(negedge clk);
            chk("feat_rd_a", 32'(ifa.feat_data), 32'(feat_a[id_a % 8]));
            repeat (lat_a) @(posedge clk);
            #1 ifa.eng_done = 1'b1; ifa.eng_class = cls_a[id_a];
            @(posedge clk); #1 ifa.eng_done = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (ifb.eng_start) begin
            id_b = int'(ifb.eng_tree_id);
            chk("tree_id_b", 32'(ifb.eng_tree_id), 32'(ecnt_b));
            ecnt_b++;
            @(posedge clk); #1 ifb.feat_idx = 3'(id_b % 8);
            @(negedge clk);
            chk("feat_rd_b", 32'(ifb.feat_data), 32'(feat_b[id_b % 8]));
            repeat (lat_b) @(posedge clk);
            #1 ifb.eng_done = 1'b1; ifb.eng_class = cls_b[id_b];
            @(posedge clk); #1 ifb.eng_done = 1'b0;
        end
    end

    // Monitors: every accepted tx byte is popped against the scoreboard
    initial forever begin
        @(negedge clk);
        if (ifa.tx_valid && ifa.tx_ready) begin
            if (qa.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL tx_unexpected_a: got %0h, expected no transfer", ifa.tx_data);
            end else begin
                logic [7:0] e;
                e = qa.pop_front();
                chk("tx_data_a", 32'(ifa.tx_data), 32'(e));
                chk("result_a", 32'(ifa.result), 32'(e - ASCII_ZERO));
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (ifb.tx_valid && ifb.tx_ready) begin
            if (qb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL tx_unexpected_b: got %0h, expected no transfer", ifb.tx_data);
            end else begin
                logic [7:0] e;
                e = qb.pop_front();
                chk("tx_data_b", 32'(ifb.tx_data), 32'(e));
                chk("result_b", 32'(ifb.result), 32'(e - ASCII_ZERO));
            end
        end
    end

    task automatic send_bytes(input int d, input logic [7:0] base, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            @(posedge clk); #1;
            if (d == 0) begin
                ifa.rx_valid = 1'b1; ifa.rx_data = base + 8'(i); feat_a[i] = base + 8'(i);
            end else begin
                ifb.rx_valid = 1'b1; ifb.rx_data = base + 8'(i); feat_b[i] = base + 8'(i);
            end
        end
        @(posedge clk); #1;
        ifa.rx_valid = 1'b0;
        ifb.rx_valid = 1'b0;
    endtask

    task automatic run_sample(input int d, input logic [7:0] base, input logic [7:0] exp_tx);
        if (d == 0) begin ecnt_a = 0; qa.push_back(exp_tx); end
        else        begin ecnt_b = 0; qb.push_back(exp_tx); end
        send_bytes(d, base, 0, 7);
    endtask

    task automatic finish_sample(input int d, input string tag);
        int c = 0;
        while (((d == 0) ? qa.size() : qb.size()) != 0 && c < 4000) begin
            @(posedge clk); #1;
            c++;
        end
        if (c >= 4000) begin
            n_vec++; n_err++;
            $display("FAIL %s_timeout: transfer still pending after %0d cycles, expected accepted", tag, c);
        end
        @(negedge clk);
        chk({tag, "_busy"}, 32'((d == 0) ? ifa.busy : ifb.busy), 32'd0);
        chk({tag, "_trees"}, 32'((d == 0) ? ecnt_a : ecnt_b), 32'd16);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int starts;
        rst = 1'b1;
        ifa.rx_valid = 1'b0; ifa.rx_data = '0; ifa.feat_idx = '0;
        ifa.eng_done = 1'b0; ifa.eng_class = '0; ifa.tx_ready = 1'b1;
        ifb.rx_valid = 1'b0; ifb.rx_data = '0; ifb.feat_idx = '0;
        ifb.eng_done = 1'b0; ifb.eng_class = '0; ifb.tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_busy", 32'(ifa.busy), 32'd0);
        chk("rst_tx_valid", 32'(ifa.tx_valid), 32'd0);
        chk("rst_tx_data", 32'(ifa.tx_data), 32'd0);
        chk("rst_result", 32'(ifa.result), 32'd0);
        chk("rst_bad_a", 32'(ifa.bad_class), 32'd0);
        chk("rst_bad_b", 32'(ifb.bad_class), 32'd0);
        chk("rst_tree_id", 32'(ifa.eng_tree_id), 32'd0);
        chk("rst_eng_start", 32'(ifa.eng_start), 32'd0);
        chk("rst_feat", 32'(ifa.feat_data), 32'd0);

        // Unanimous class 2, bytes 01..08
        for (int t = 0; t < 16; t++) cls_a[t] = 2'd2;
        lat_a = 2;
        run_sample(0, 8'h01, 8'h32);
        finish_sample(0, "all2");

        // 5 / 5 / 0 / 6 votes
        for (int t = 0; t < 16; t++) cls_a[t] = (t < 5) ? 2'd0 : (t < 10) ? 2'd1 : 2'd3;
        lat_a = 1;
        run_sample(0, 8'h11, 8'h33);
        finish_sample(0, "c3win");

        // 8 / 8 tie between classes 1 and 2
        for (int t = 0; t < 16; t++) cls_a[t] = (t < 8) ? 2'd2 : 2'd1;
        run_sample(0, 8'h21, 8'h31);
        finish_sample(0, "tie");

        // Stalled transmitter, rx bytes thrown at the busy controller
        for (int t = 0; t < 16; t++) cls_a[t] = (t < 9) ? 2'd0 : 2'd3;
        ifa.tx_ready = 1'b0;
        run_sample(0, 8'h41, 8'h30);
        c = 0;
        while (!ifa.tx_valid && c < 4000) begin @(negedge clk); c++; end
        chk("hold_tx_seen", 32'(ifa.tx_valid), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            ifa.rx_valid = (i < 8);
            ifa.rx_data  = 8'hA0 + 8'(i);
            @(negedge clk);
            chk("hold_valid", 32'(ifa.tx_valid), 32'd1);
            chk("hold_data", 32'(ifa.tx_data), 32'h30);
        end
        @(posedge clk); #1;
        ifa.rx_valid = 1'b0;
        ifa.tx_ready = 1'b1;
        finish_sample(0, "hold");
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1 ifa.feat_idx = 3'(i);
            @(negedge clk);
            chk("feat_frozen", 32'(ifa.feat_data), 32'(8'h41 + 8'(i)));
        end

        // Seven bytes must not start a sample; the eighth does
        for (int t = 0; t < 16; t++) cls_a[t] = (t % 3 == 0) ? 2'd0 : 2'd1;
        ecnt_a = 0;
        qa.push_back(8'h31);
        send_bytes(0, 8'h51, 0, 6);
        @(negedge clk);
        chk("partial_busy", 32'(ifa.busy), 32'd0);
        send_bytes(0, 8'h51, 7, 7);
        @(negedge clk);
        chk("full_busy", 32'(ifa.busy), 32'd1);
        finish_sample(0, "split");

        // Reset while waiting on tree 7
        for (int t = 0; t < 16; t++) cls_a[t] = 2'd2;
        lat_a = 3;
        ecnt_a = 0;
        send_bytes(0, 8'h61, 0, 7);
        c = 0;
        while (ecnt_a < 8 && c < 2000) begin @(posedge clk); #1; c++; end
        chk("rst_at_tree7", 32'(ecnt_a), 32'd8);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(ifa.busy), 32'd0);
        chk("midrst_tx_valid", 32'(ifa.tx_valid), 32'd0);
        chk("midrst_result", 32'(ifa.result), 32'd0);
        chk("midrst_eng_start", 32'(ifa.eng_start), 32'd0);
        chk("midrst_tree_id", 32'(ifa.eng_tree_id), 32'd0);
        chk("midrst_feat", 32'(ifa.feat_data), 32'd0);
        starts = 0;
        repeat (8) begin
            @(negedge clk);
            if (ifa.eng_start) starts++;
        end
        chk("midrst_idle_starts", 32'(starts), 32'd0);

        // Fresh sample after the reset restarts at tree 0
        for (int t = 0; t < 16; t++) cls_a[t] = 2'd1;
        lat_a = 1;
        run_sample(0, 8'h71, 8'h31);
        finish_sample(0, "restart");

        // Three-class controller: tree 4 reports out-of-range class 3
        for (int t = 0; t < 16; t++) cls_b[t] = (t == 4) ? 2'd3 : (t < 10) ? 2'd2 : 2'd0;
        run_sample(1, 8'h81, 8'h32);
        finish_sample(1, "badcls");
        chk("bad_set_b", 32'(ifb.bad_class), 32'd1);
        chk("bad_clear_a", 32'(ifa.bad_class), 32'd0);

        for (int t = 0; t < 16; t++) cls_b[t] = 2'd1;
        run_sample(1, 8'h91, 8'h31);
        finish_sample(1, "sticky");
        chk("bad_sticky_b", 32'(ifb.bad_class), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
